// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the data stage.
// Alternating-priority arbitration, single-owner access sequencing, per-stage stalls.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_dm
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_dm_q, last_dm_d;
    logic                owner_dm_q, owner_dm_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                if_valid_q, if_valid_d;
    logic                dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

    logic dm_req;
    logic grant_dm;

    assign dm_req   = mem_read | mem_write;
    // On a tie the stage that did not win last time gets the port.
    assign grant_dm = dm_req & (~if_req | ~last_dm_q);

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        owner_dm_d  = owner_dm_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req | dm_req) begin
                    state_d     = BUSY;
                    cnt_d       = CNT_W'(MEM_LATENCY);
                    owner_dm_d  = grant_dm;
                    last_dm_d   = grant_dm;
                    ram_en_d    = 1'b1;
                    ram_we_d    = grant_dm & mem_write;
                    ram_addr_d  = grant_dm ? dm_addr : if_addr;
                    ram_wdata_d = grant_dm ? dm_wdata : '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = '0;
                    ram_wdata_d = '0;
                    if (owner_dm_q) begin
                        dm_rdata_d = ram_rdata;
                        dm_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = ram_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dm_q   <= 1'b0;
            owner_dm_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            owner_dm_q  <= owner_dm_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stalls react to the live request lines so a stage releases on its valid cycle.
    assign stall_if = if_req & ~if_valid_q;
    assign stall_dm = dm_req & ~dm_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified memory between instruction fetch (IF) and the data-memory stage (MEM) of the pipelined core. It accepts IF fetch requests and the decoded `mem_read`/`mem_write` strobes from the control unit, grants the memory port to one requester at a time, and sequences a fixed-latency access. It returns read data with a one-cycle valid pulse and drives per-stage stall signals to the pipeline registers.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LATENCY`, 1, cycles from the `ram_en` cycle to valid `ram_rdata`; legal values are 1 to 15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, held until `if_valid`.
- `if_addr`  in  ADDR_W  fetch address (PC).
- `mem_read`  in  1  data read request, from the control unit. It is also high for sw.
- `mem_write`  in  1  data write request, from the control unit.
- `dm_addr`  in  ADDR_W  data address (ALU result).
- `dm_wdata`  in  DATA_W  store data.
- `ram_rdata`  in  DATA_W  memory read data.
- `ram_en`  out  1  memory access strobe.
- `ram_we`  out  1  write enable, qualified by `ram_en`.
- `ram_addr`  out  ADDR_W  memory address.
- `ram_wdata`  out  DATA_W  memory write data.
- `if_valid`  out  1  one-cycle completion pulse for a fetch.
- `if_rdata`  out  DATA_W  fetched instruction, valid while `if_valid` is high.
- `dm_valid`  out  1  one-cycle completion pulse for a data access (read or write).
- `dm_rdata`  out  DATA_W  load data, valid while `dm_valid` is high.
- `stall_if`  out  1  `if_req & ~if_valid`.
- `stall_dm`  out  1  `(mem_read | mem_write) & ~dm_valid`.

## Operation
- DM request `dm_req` is `mem_read | mem_write`. A write is `mem_write=1`, regardless of `mem_read`.
- States:
  - IDLE: arbitrate. If any request is present, latch owner, address, `we` and wdata, load the counter with `MEM_LATENCY`, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: `ram_en=1` in the first BUSY cycle only. Decrement the counter each cycle. When the counter hits 0, capture `ram_rdata` into the owner's rdata register and go to DONE.
  - DONE: assert the owner's valid for exactly one cycle, then go to IDLE. No arbitration happens in DONE, because the requester still holds the completed request that cycle.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both requesting: grant the one that was not granted last, tracked by `last_dm`.
  - `last_dm` updates on every grant. It resets to 0, so DM wins the first tie.
- Address, write data and `we` are latched at grant. Input changes during BUSY or DONE are ignored.
- A request dropped before completion still runs to DONE. The valid pulse is still emitted.
- For writes, `dm_rdata` holds whatever `ram_rdata` returned and has no meaning.
- `ram_addr`, `ram_wdata` and `ram_we` are driven from the latched values throughout BUSY. They are 0 in IDLE and DONE.

## Timing
- Reset: state IDLE, counter 0, `last_dm=0`.
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `if_valid`, `dm_valid`, `if_rdata` and `dm_rdata` are all 0.
  - `stall_*` follow their equations with valid=0.
- Reset asserted mid-BUSY or in DONE aborts the access. No valid pulse is produced and IDLE is entered on the next edge.
- Cycle numbering: request seen in IDLE at cycle 0.
  - `ram_en` is high in cycle 1.
  - `ram_rdata` is sampled at the end of cycle `MEM_LATENCY`.
  - Valid is high in cycle `MEM_LATENCY+1`.
  - IDLE is entered in cycle `MEM_LATENCY+2`.
  - Throughput is one access per `MEM_LATENCY+2` cycles.
- Worst-case wait for a continuously requesting stage is one full access of the other stage.
- `stall_*` are combinational from the inputs and the registered valids. A stage advances on the edge ending its valid cycle.

## Test plan
- Single fetch, `MEM_LATENCY=1`: `if_req=1`, `if_addr=0x40`, memory returns `0x2008000A`. Required: `ram_en` high in cycle 1 with `ram_addr=0x40`; `if_valid=1` with `if_rdata=0x2008000A` in cycle 2; `stall_if` high in cycles 0–1 and low in cycle 2.
- sw with `mem_read=1`, `mem_write=1`, `dm_addr=0x100`, `dm_wdata=0xDEADBEEF`. Required: `ram_en=1`, `ram_we=1`, `ram_wdata=0xDEADBEEF` for exactly one cycle; `dm_valid` pulses one cycle later.
- lw (`mem_read=1` only) at `0x104` returning `0x12345678`. Required: `ram_we=0`; `dm_rdata=0x12345678` with `dm_valid`.
- `if_req` and `mem_read` both held high continuously after reset. Required: grants go DM, IF, DM, IF; each valid pulse is 3 cycles apart at `MEM_LATENCY=1`; the non-owner's stall stays high throughout.
- Reset pulsed in the second BUSY cycle of a `MEM_LATENCY=3` fetch. Required: no `if_valid`; all outputs 0 the cycle after reset; a new request is granted in the first cycle after reset deasserts.
- `MEM_LATENCY=3`, `if_addr` changed during BUSY. Required: `ram_addr` keeps the granted address; `if_valid` appears in cycle 4.
